alu_issue: RTL and testbench

Execute-stage issue and collect block for RV32I integer ALU instructions. It accepts a decoded-stage instruction with operand values over a valid/ready handshake and registers it in an issue stage. It decodes OP/OP-IMM into a one-hot enable vector, drives the ten enable-gated op units (add, sub, xor, or, and, sll, srl, sra, slt, sltu) and ORs their gated results. The result is registered into a writeback stage with its own valid/ready handshake.

---
 rtl/alu_issue.sv | 203 ++++++++++++++++++++
 tb/tb_alu_issue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32I integer ALU issue/collect: S1 issue register with a one-hot op decode,
// ten enable-gated op units OR-combined, S2 result register with valid/ready out.

module alu_op_unit #(
  parameter int unsigned OP = 0
) (
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res
);
  logic [31:0] r;
  // shift units only look at b[4:0]
  wire unused_b = &{1'b0, b};

  always_comb begin
    case (OP)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a ^ b;
      3:       r = a | b;
      4:       r = a & b;
      5:       r = a << b[4:0];
      6:       r = a >> b[4:0];
      7:       r = $unsigned($signed(a) >>> b[4:0]);
      8:       r = {31'd0, $signed(a) < $signed(b)};
      9:       r = {31'd0, a < b};
      default: r = '0;
    endcase
  end

  assign res = en ? r : '0;
endmodule

module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [31:0] out_result,
  output logic        out_illegal
);
  localparam int NUM_OPS = 10;
  localparam int ADD = 0, SUB = 1, XOR = 2, OR = 3, AND = 4,
                 SLL = 5, SRL = 6, SRA = 7, SLT = 8, SLTU = 9;
  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] result;
    logic        illegal;
  } res_t;

  // ---------------- decode ----------------
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       f7_zero, f7_alt;
  logic [NUM_OPS-1:0] dec_en;
  wire unused_instr = &{1'b0, in_instr[19:15]};

  assign opcode  = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  always_comb begin
    dec_en = '0;
    if (opcode == OPC_OP) begin
      case (f3)
        3'b000: begin
          dec_en[ADD] = f7_zero;
          dec_en[SUB] = f7_alt;
        end
        3'b001: dec_en[SLL]  = f7_zero;
        3'b010: dec_en[SLT]  = f7_zero;
        3'b011: dec_en[SLTU] = f7_zero;
        3'b100: dec_en[XOR]  = f7_zero;
        3'b101: begin
          dec_en[SRL] = f7_zero;
          dec_en[SRA] = f7_alt;
        end
        3'b110: dec_en[OR]   = f7_zero;
        default: dec_en[AND] = f7_zero;
      endcase
    end else if (opcode == OPC_IMM) begin
      // immediate forms: no subi, and only the shifts constrain instr[31:25]
      case (f3)
        3'b000: dec_en[ADD]  = 1'b1;
        3'b001: dec_en[SLL]  = f7_zero;
        3'b010: dec_en[SLT]  = 1'b1;
        3'b011: dec_en[SLTU] = 1'b1;
        3'b100: dec_en[XOR]  = 1'b1;
        3'b101: begin
          dec_en[SRL] = f7_zero;
          dec_en[SRA] = f7_alt;
        end
        3'b110: dec_en[OR]   = 1'b1;
        default: dec_en[AND] = 1'b1;
      endcase
    end
  end

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid, s1_load, s2_load;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // ---------------- S1 issue register ----------------
  logic [NUM_OPS-1:0] s1_op_en;
  logic [31:0]        s1_rs1, s1_rs2;
  logic [11:0]        s1_imm;
  logic [4:0]         s1_rd;
  logic               s1_use_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s1_valid <= 1'b0;
    else if (flush)
      s1_valid <= 1'b0;
    else if (s1_load)
      s1_valid <= 1'b1;
    else if (s2_load)
      s1_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (s1_load && !flush) begin
      s1_op_en   <= dec_en;
      s1_rs1     <= in_rs1_val;
      s1_rs2     <= in_rs2_val;
      s1_imm     <= in_instr[31:20];
      s1_rd      <= in_instr[11:7];
      s1_use_imm <= (opcode == OPC_IMM);
    end
  end

  // ---------------- op units ----------------
  logic [31:0]                    op_b;
  logic [NUM_OPS-1:0][31:0]       unit_res;
  logic [31:0]                    alu_res;

  assign op_b = s1_use_imm ? {{20{s1_imm[11]}}, s1_imm} : s1_rs2;

  generate
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_unit
      alu_op_unit #(.OP(i)) u_op (
        .en  (s1_op_en[i]),
        .a   (s1_rs1),
        .b   (op_b),
        .res (unit_res[i])
      );
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    for (int i = 0; i < NUM_OPS; i++)
      alu_res = alu_res | unit_res[i];
  end

  // ---------------- S2 result register ----------------
  res_t s2_q, s2_d;

  assign s2_d.rd      = s1_rd;
  assign s2_d.illegal = (s1_op_en == '0);
  assign s2_d.we      = !s2_d.illegal && (s1_rd != 5'd0);
  assign s2_d.result  = alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_q     <= s2_d;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_rd      = s2_q.rd;
  assign out_we      = s2_q.we;
  assign out_result  = s2_q.result;
  assign out_illegal = s2_q.illegal;

  // decoder must never select more than one unit
  a_dec_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dec_en));
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed vectors push expectations at accept,
// a negedge monitor pops and compares on every output transfer.

module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_rs1_val, in_rs2_val, out_result;
  logic [4:0]  out_rd;
  logic        out_we, out_illegal;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] res;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];
  int   checks = 0, errors = 0, cyc = 0;
  logic stall_v = 1'b0;
  exp_t stall_p;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_we(out_we), .out_result(out_result), .out_illegal(out_illegal)
  );

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: compares every transfer and the stability of stalled payloads
  always @(negedge clk) begin
    exp_t cur, e;
    cur = '{out_rd, out_we, out_result, out_illegal};
    if (!rst_n) stall_v = 1'b0;
    else begin
      if (stall_v) begin
        checks++;
        if (!out_valid || cur !== stall_p) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h", out_valid, cur, stall_p);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %0h expected no output", cur);
        end else begin
          e = q.pop_front();
          pop_cyc.push_back(cyc);
          if (cur !== e) begin
            errors++;
            $display("FAIL result: got rd=%0d we=%0b res=%0h ill=%0b expected rd=%0d we=%0b res=%0h ill=%0b",
                     cur.rd, cur.we, cur.res, cur.ill, e.rd, e.we, e.res, e.ill);
          end
        end
      end
      stall_v = out_valid && !out_ready && !flush;
      stall_p = cur;
    end
  end

  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_instr = instr; in_rs1_val = a; in_rs2_val = b;
  endtask

  task automatic wait_accept(input exp_t e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        q.push_back(e);
        #1 in_valid = 1'b0;
        return;
      end
    end
    errors++;
    $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic we, input logic [31:0] res, input logic ill);
    drive(instr, a, b);
    wait_accept('{rd, we, res, ill});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
    #12;
    check("reset_out", {out_valid, out_we, out_illegal, out_rd, out_result}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // ADD with latency check
    send(32'h002081B3, 5, 7, 3, 1, 12, 0);
    @(negedge clk); check("lat_s1_only", out_valid, 0);
    @(negedge clk); check("lat_out_valid", out_valid, 1);
    idle(2);

    // back-to-back sub / sra / sltu
    send(r_op(7'h20, 3'b000, 4), 3, 5, 4, 1, 32'hFFFFFFFE, 0);
    send(r_op(7'h20, 3'b101, 5), 32'h80000000, 4, 5, 1, 32'hF8000000, 0);
    send(r_op(7'h00, 3'b011, 6), 1, 32'hFFFFFFFF, 6, 1, 1, 0);
    idle(4);
    n = pop_cyc.size();
    check("b2b_consecutive", (n >= 3) ? pop_cyc[n-1] - pop_cyc[n-3] : 0, 2);

    // remaining ops
    send(r_op(7'h00, 3'b100, 11), 32'hF0F0, 32'hFF00, 11, 1, 32'h0FF0, 0);
    send(r_op(7'h00, 3'b110, 12), 32'hF0F0, 32'hFF00, 12, 1, 32'hFFF0, 0);
    send(r_op(7'h00, 3'b111, 13), 32'hF0F0, 32'hFF00, 13, 1, 32'hF000, 0);
    send(r_op(7'h00, 3'b001, 14), 1, 32'h3F, 14, 1, 32'h80000000, 0);
    send(r_op(7'h00, 3'b101, 15), 32'h80000000, 4, 15, 1, 32'h08000000, 0);
    send(r_op(7'h00, 3'b010, 16), 32'hFFFFFFFF, 1, 16, 1, 1, 0);

    // OP-IMM
    send(i_op(12'hFFF, 3'b000, 7), 0, 32'h1234, 7, 1, 32'hFFFFFFFF, 0);
    send(i_op(12'h41F, 3'b101, 8), 32'h80000000, 0, 8, 1, 32'hFFFFFFFF, 0);
    send(i_op(12'h400, 3'b000, 17), 1, 0, 17, 1, 32'h401, 0);

    // illegal and rd = x0
    send({25'h0, 7'b0000011} | (32'd9 << 7), 1, 2, 9, 0, 0, 1);
    send(r_op(7'h01, 3'b000, 10), 1, 2, 10, 0, 0, 1);
    send(i_op(12'h401, 3'b001, 18), 1, 2, 18, 0, 0, 1);
    send(r_op(7'h00, 3'b000, 0), 1, 2, 0, 0, 3, 0);
    idle(3);

    // backpressure: two captured, third blocked
    out_ready = 1'b0;
    send(r_op(7'h00, 3'b000, 20), 10, 1, 20, 1, 11, 0);
    send(r_op(7'h00, 3'b000, 21), 10, 2, 21, 1, 12, 0);
    drive(r_op(7'h00, 3'b000, 22), 10, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept('{5'd22, 1'b1, 32'd13, 1'b0});
    idle(4);

    // flush with both stages full, then flush with a same-cycle input
    out_ready = 1'b0;
    send(r_op(7'h00, 3'b000, 23), 1, 1, 23, 1, 2, 0);
    send(r_op(7'h00, 3'b000, 24), 1, 2, 24, 1, 3, 0);
    flush = 1'b1;
    drive(r_op(7'h00, 3'b000, 25), 1, 3);
    @(posedge clk); #1;
    q.delete();
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); n += out_valid; end
    check("flush_drop", n, 0);
    @(posedge clk); #1;

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(r_op(7'h00, 3'b000, 26), 4, 4, 26, 1, 8, 0);
    send(r_op(7'h00, 3'b000, 27), 4, 5, 27, 1, 9, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", {out_valid, out_we, out_illegal, out_rd, out_result}, '0);
    check("async_rst_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    send(r_op(7'h00, 3'b000, 28), 100, 23, 28, 1, 123, 0);
    idle(4);
    check("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by 100us");
    $fatal(1);
  end
endmodule
